// File: rtl/square_pkg.sv
// Shared types and limits for the square_mac datapath.
package square_pkg;

  typedef enum logic [1:0] {
    MODE_SQ,
    MODE_MUL,
    MODE_ACC,
    MODE_ACC_CLR
  } mode_t;

  localparam int unsigned MAX_STAGES = 4;

endpackage

// File: rtl/square_mac_pipe_mult.sv
// Unsigned WIDTH x WIDTH multiplier spread over STAGES registers, with the beat's
// valid bit and mode tag carried alongside so they emerge aligned with the product.
module pipe_mult
  import square_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  input  logic               valid_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  mode_t              tag_in,
  output logic [2*WIDTH-1:0] prod_out,
  output logic               valid_out,
  output mode_t              tag_out
);

  logic [2*WIDTH-1:0] prod_q [STAGES];
  mode_t              tag_q  [STAGES];
  logic [STAGES-1:0]  valid_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (en_in) begin
      valid_q[0] <= valid_in;
      for (int unsigned s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Data registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk_in) begin
    if (en_in) begin
      prod_q[0] <= (2*WIDTH)'(a_in) * (2*WIDTH)'(b_in);
      tag_q[0]  <= tag_in;
      for (int unsigned s = 1; s < STAGES; s++) begin
        prod_q[s] <= prod_q[s-1];
        tag_q[s]  <= tag_q[s-1];
      end
    end
  end

  assign prod_out  = prod_q[STAGES-1];
  assign valid_out = valid_q[STAGES-1];
  assign tag_out   = tag_q[STAGES-1];

endmodule

// File: rtl/square_mac.sv
// Pipelined squarer/multiplier with saturating running accumulator and
// valid/ready handshakes on both sides; a downstream stall freezes every stage.
module square_mac
  import square_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [1:0]           mode_in,
  output logic [ACC_WIDTH-1:0] result_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 overflow_out
);

  logic                 stall;
  logic                 accept;
  logic                 in_valid_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  mode_t                mode_q;
  logic                 m_valid;
  mode_t                m_tag;
  logic [2*WIDTH-1:0]   m_prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] res_q, res_d;
  logic                 ovf_q, ovf_d;
  logic                 vout_q, vout_d;

  assign stall     = vout_q && !ready_in;
  assign ready_out = !stall && !rst_in;
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_valid_q <= 1'b0;
    end else if (!stall) begin
      in_valid_q <= valid_in;
    end
  end

  // The multiplier always sees a*b; squaring modes feed a into both operands.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      a_q    <= a_in;
      b_q    <= (mode_t'(mode_in) == MODE_MUL) ? b_in : a_in;
      mode_q <= mode_t'(mode_in);
    end
  end

  pipe_mult #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_pipe_mult (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (!stall),
    .valid_in  (in_valid_q),
    .a_in      (a_q),
    .b_in      (b_q),
    .tag_in    (mode_q),
    .prod_out  (m_prod),
    .valid_out (m_valid),
    .tag_out   (m_tag)
  );

  assign prod_ext = ACC_WIDTH'(m_prod);
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};

  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    vout_d = vout_q;
    if (!stall) begin
      vout_d = m_valid;
      if (m_valid) begin
        unique case (m_tag)
          MODE_SQ, MODE_MUL: res_d = prod_ext;
          MODE_ACC: begin
            if (sum[ACC_WIDTH]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum[ACC_WIDTH-1:0];
            end
            res_d = acc_d;
          end
          MODE_ACC_CLR: begin
            acc_d = prod_ext;
            ovf_d = 1'b0;
            res_d = prod_ext;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      vout_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      res_q  <= res_d;
      vout_q <= vout_d;
    end
  end

  assign result_out   = res_q;
  assign valid_out    = vout_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_square_mac.sv
// Randomised and directed bench for square_mac, scored against an integer model
// of the square/multiply/accumulate rules.
module tb_square_mac;

  localparam int unsigned W  = 16;
  localparam int unsigned S  = 2;
  localparam int unsigned AW = 2*W+8;
  localparam longint unsigned ACC_MAX = (64'd1 << AW) - 64'd1;

  logic          clk_in = 1'b0;
  logic          rst_in, valid_in, ready_out, ready_in, valid_out, overflow_out;
  logic [W-1:0]  a_in, b_in;
  logic [1:0]    mode_in;
  logic [AW-1:0] result_out;

  // Small instance for the narrow saturation case.
  logic       s_valid_in, s_ready_out, s_valid_out, s_overflow_out;
  logic [3:0] s_a_in, s_b_in;
  logic [1:0] s_mode_in;
  logic [8:0] s_result_out;
  logic       s_ready_in = 1'b1;

  always #5 clk_in = ~clk_in;

  square_mac #(.WIDTH(W), .STAGES(S), .ACC_WIDTH(AW)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .a_in         (a_in),
    .b_in         (b_in),
    .mode_in      (mode_in),
    .result_out   (result_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .overflow_out (overflow_out)
  );

  square_mac #(.WIDTH(4), .STAGES(2), .ACC_WIDTH(9)) dut_small (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (s_valid_in),
    .ready_out    (s_ready_out),
    .a_in         (s_a_in),
    .b_in         (s_b_in),
    .mode_in      (s_mode_in),
    .result_out   (s_result_out),
    .valid_out    (s_valid_out),
    .ready_in     (s_ready_in),
    .overflow_out (s_overflow_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    longint unsigned res;
    bit              ovf;
  } exp_t;

  exp_t            exp_q[$];
  longint unsigned seen_q[$];
  longint unsigned m_acc = 0;
  bit              m_ovf = 0;

  function automatic exp_t model_beat(input int unsigned mode, input longint unsigned a,
                                      input longint unsigned b);
    exp_t r;
    longint unsigned p = (mode == 1) ? a * b : a * a;
    case (mode)
      2: begin
        if (m_acc + p > ACC_MAX) begin
          m_acc = ACC_MAX;
          m_ovf = 1'b1;
        end else begin
          m_acc = m_acc + p;
        end
        r.res = m_acc;
      end
      3: begin
        m_acc = p;
        m_ovf = 1'b0;
        r.res = p;
      end
      default: r.res = p;
    endcase
    r.ovf = m_ovf;
    return r;
  endfunction

  // Scoreboard: all inputs change at posedge+1, so negedge sees the values
  // that the next posedge will act on.
  initial begin
    exp_t          e;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_res   = '0;
    forever begin
      @(negedge clk_in);
      check_eq("ready_out", ready_out, !(valid_out && !ready_in) && !rst_in);
      if (prev_stall) begin
        check_eq("hold_valid", valid_out, 1);
        check_eq("hold_result", result_out, prev_res);
      end
      prev_stall = valid_out && !ready_in && !rst_in;
      prev_res   = result_out;
      if (rst_in) begin
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
      end else begin
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_valid", valid_out, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("result", result_out, e.res);
            check_eq("overflow", overflow_out, e.ovf);
          end
          seen_q.push_back(result_out);
        end
        if (valid_in && ready_out) exp_q.push_back(model_beat(mode_in, a_in, b_in));
      end
    end
  end

  longint unsigned s_res_q[$];
  bit              s_ovf_q[$];
  initial forever begin
    @(negedge clk_in);
    if (s_valid_out && !rst_in) begin
      s_res_q.push_back(s_result_out);
      s_ovf_q.push_back(s_overflow_out);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int unsigned mode, input longint unsigned a, input longint unsigned b);
    valid_in = 1'b1;
    mode_in  = 2'(mode);
    a_in     = W'(a);
    b_in     = W'(b);
    for (int t = 0; !ready_out && t < 100; t++) tick();
    if (!ready_out) check_eq("send_timeout", 0, 1);
    tick();
  endtask

  task automatic drain();
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int t = 0; exp_q.size() != 0 && t < 100; t++) tick();
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  // Call right after send(): beat accepted at edge N must appear after N+S+1.
  task automatic check_latency(input string tag);
    valid_in = 1'b0;
    for (int k = 1; k <= int'(S) + 2; k++) begin
      @(negedge clk_in);
      check_eq(tag, valid_out, (k == int'(S) + 2));
    end
    tick();
  endtask

  task automatic check_seen(input string tag, input longint unsigned exp[]);
    check_eq({tag, "_count"}, seen_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen_q.size(); i++) check_eq(tag, seen_q[i], exp[i]);
    seen_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    longint unsigned s_exp_res[4] = '{225, 450, 511, 1};
    bit              s_exp_ovf[4] = '{0, 0, 1, 0};

    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    a_in = '0; b_in = '0; mode_in = '0;
    s_valid_in = 1'b0; s_a_in = '0; s_b_in = '0; s_mode_in = '0;
    tick(); tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_result", result_out, 0);
    check_eq("rst_overflow", overflow_out, 0);
    tick();

    // Square of all-ones with latency check.
    seen_q.delete();
    send(0, 'hFFFF, 0);
    check_latency("sq_latency");
    check_seen("sq_ffff", '{64'hFFFE_0001});
    check_eq("sq_overflow", overflow_out, 0);

    // Back-to-back multiplies.
    send(1, 3, 5); send(1, 7, 9); send(1, 0, 'hFFFF);
    drain();
    check_seen("mul_b2b", '{15, 63, 0});

    // Accumulate with an interleaved square.
    send(3, 3, 0); send(2, 4, 0); send(0, 10, 0); send(2, 2, 0);
    drain();
    check_seen("acc_seq", '{9, 25, 100, 29});

    // Wide saturation: ~257 beats of 0xFFFF^2 exceed 40 bits.
    send(3, 'hFFFF, 0);
    for (int i = 0; i < 260; i++) send(2, 'hFFFF, 0);
    drain();
    check_eq("sat_result", seen_q[seen_q.size()-1], ACC_MAX);
    check_eq("sat_overflow", overflow_out, 1);
    seen_q.delete();
    send(0, 2, 0);
    drain();
    check_eq("sat_sticky", overflow_out, 1);
    send(3, 1, 0);
    drain();
    check_eq("clr_overflow", overflow_out, 0);
    seen_q.delete();

    // Backpressure on the first result.
    for (int i = 1; i <= 4; i++) send(0, i, 0);
    valid_in = 1'b0;
    for (t = 0; !valid_out && t < 20; t++) tick();
    check_eq("bp_first_valid", valid_out, 1);
    ready_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      check_eq("bp_hold", result_out, 1);
      check_eq("bp_ready", ready_out, 0);
    end
    tick();
    drain();
    check_seen("bp_order", '{1, 4, 9, 16});

    // Reset during a stall.
    ready_in = 1'b0;
    send(0, 5, 0); send(0, 6, 0); send(0, 7, 0);
    valid_in = 1'b0;
    for (t = 0; !valid_out && t < 20; t++) tick();
    check_eq("rst_stall_valid", valid_out, 1);
    tick();
    rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("rst_ready", ready_out, 0);
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check_eq("rst_mid_valid", valid_out, 0);
    check_eq("rst_mid_result", result_out, 0);
    check_eq("rst_mid_overflow", overflow_out, 0);
    check_eq("rst_mid_ready", ready_out, 1);
    tick();
    ready_in = 1'b1;
    seen_q.delete();
    repeat (8) tick();
    check_eq("rst_no_stale", seen_q.size(), 0);
    send(0, 6, 0);
    check_latency("rst_latency");
    check_seen("rst_new", '{36});

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      valid_in = ($urandom_range(0, 9) < 7);
      ready_in = ($urandom_range(0, 9) < 7);
      mode_in  = 2'($urandom_range(0, 3));
      a_in     = ($urandom_range(0, 3) == 0) ? W'('hFFFF) : W'($urandom);
      b_in     = W'($urandom);
      tick();
    end
    drain();
    seen_q.delete();

    // Narrow saturation on the 4-bit instance.
    for (int i = 0; i < 4; i++) begin
      s_valid_in = 1'b1;
      s_mode_in  = (i == 1 || i == 2) ? 2'd2 : 2'd3;
      s_a_in     = (i == 3) ? 4'd1 : 4'd15;
      tick();
    end
    s_valid_in = 1'b0;
    repeat (6) tick();
    check_eq("small_count", s_res_q.size(), 4);
    for (int i = 0; i < 4 && i < s_res_q.size(); i++) begin
      check_eq("small_result", s_res_q[i], s_exp_res[i]);
      check_eq("small_overflow", s_ovf_q[i], s_exp_ovf[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
